// File: rtl/pht_lookup.sv
// Pattern history table of 2-bit direction counters: registered lookup with
// ready/valid backpressure, resolution write-back and a saturating mispredict count.
module pht_lookup #(
    parameter int unsigned IDX_W      = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [1:0]       rsp_state,
    output logic             rsp_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [1:0]       upd_state,
    input  logic             upd_taken,
    output logic             mispredict,
    output logic [15:0]      mispredict_cnt
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [1:0]       table_q [ENTRIES];
    logic [1:0]       table_d [ENTRIES];
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
    logic [1:0]       rsp_state_q, rsp_state_d;
    logic             mispredict_q, mispredict_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             upd_miss;
    logic [1:0]       upd_next_state;
    logic             req_fire;

    // Next counter value derives from the state carried with the branch,
    // not from whatever the table holds now.
    always_comb begin
        upd_miss       = upd_state[1] != upd_taken;
        upd_next_state = upd_state;
        case ({upd_state, upd_miss})
            3'b000:  upd_next_state = 2'b00;
            3'b001:  upd_next_state = 2'b01;
            3'b010:  upd_next_state = 2'b00;
            3'b011:  upd_next_state = 2'b10;
            3'b100:  upd_next_state = 2'b11;
            3'b101:  upd_next_state = 2'b01;
            3'b110:  upd_next_state = 2'b11;
            3'b111:  upd_next_state = 2'b10;
            default: upd_next_state = upd_state;
        endcase
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        if (upd_valid) begin
            table_d[upd_idx] = upd_next_state;
        end
    end

    always_comb begin
        req_ready   = !rsp_valid_q || rsp_ready;
        req_fire    = req_valid && req_ready;
        rsp_valid_d = req_fire || (rsp_valid_q && !rsp_ready);
        rsp_idx_d   = rsp_idx_q;
        rsp_state_d = rsp_state_q;
        // Same-edge update to the looked-up entry wins (write-first).
        if (req_fire) begin
            rsp_idx_d   = req_idx;
            rsp_state_d = (upd_valid && (upd_idx == req_idx)) ? upd_next_state
                                                              : table_q[req_idx];
        end
    end

    always_comb begin
        mispredict_d = upd_valid && upd_miss;
        cnt_d        = cnt_q;
        if (mispredict_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= INIT_STATE;
            end
            rsp_valid_q  <= 1'b0;
            rsp_idx_q    <= '0;
            rsp_state_q  <= 2'b00;
            mispredict_q <= 1'b0;
            cnt_q        <= 16'd0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_idx_q    <= rsp_idx_d;
            rsp_state_q  <= rsp_state_d;
            mispredict_q <= mispredict_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_idx        = rsp_idx_q;
    assign rsp_state      = rsp_state_q;
    assign rsp_taken      = rsp_state_q[1];
    assign mispredict     = mispredict_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pht_lookup.sv
// Directed bench for pht_lookup: reference table model plus a response
// scoreboard filled at request acceptance and drained on handshake.
module tb_pht_lookup;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [IDX_W-1:0] req_idx = '0;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [IDX_W-1:0] rsp_idx;
    logic [1:0]       rsp_state;
    logic             rsp_taken;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic [1:0]       upd_state = 2'b00;
    logic             upd_taken = 1'b0;
    logic             mispredict;
    logic [15:0]      mispredict_cnt;

    pht_lookup #(.IDX_W(IDX_W), .INIT_STATE(2'b01)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx),
        .rsp_state(rsp_state), .rsp_taken(rsp_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
        .upd_taken(upd_taken), .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       st;
    } rsp_t;

    rsp_t        sb[$];
    logic [1:0]  ref_tbl [64];
    logic        m_rv;
    logic        exp_mp;
    int unsigned exp_cnt;
    bit          quiet;
    int          errors = 0;
    int          checks = 0;

    // Saturating up/down counter view of the transition table.
    function automatic logic [1:0] nstate(input logic [1:0] s, input logic t);
        if (t) return (s == 2'b11) ? 2'b11 : s + 2'b01;
        return (s == 2'b00) ? 2'b00 : s - 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_tbl[i] = 2'b01;
        sb.delete();
        m_rv    = 1'b0;
        exp_mp  = 1'b0;
        exp_cnt = 0;
    endtask

    // One clock: pre-edge checks on the held/shown response, model update, post-edge checks.
    task automatic step();
        logic       fire;
        logic [1:0] nxt;
        logic [1:0] rd;
        rsp_t       e;
        #1;
        if (!quiet) chk("req_ready", req_ready, (!m_rv || rsp_ready));
        fire = req_valid && (!m_rv || rsp_ready);
        nxt  = nstate(upd_state, upd_taken);
        if (m_rv && sb.size() > 0) begin
            if (!quiet) begin
                chk("rsp_idx", rsp_idx, sb[0].idx);
                chk("rsp_state", rsp_state, sb[0].st);
                chk("rsp_taken", rsp_taken, sb[0].st[1]);
            end
            if (rsp_ready) void'(sb.pop_front());
        end
        if (fire) begin
            rd = (upd_valid && upd_idx == req_idx) ? nxt : ref_tbl[req_idx];
            e.idx = req_idx;
            e.st  = rd;
            sb.push_back(e);
            if (!quiet) $display("lookup idx=%0d expect state=%b", req_idx, rd);
        end
        exp_mp = upd_valid && (upd_state[1] != upd_taken);
        if (upd_valid) ref_tbl[upd_idx] = nxt;
        if (exp_mp && exp_cnt != 32'hFFFF) exp_cnt++;
        m_rv = fire || (m_rv && !rsp_ready);
        @(posedge clk);
        #1;
        if (!quiet) begin
            chk("rsp_valid", rsp_valid, m_rv);
            chk("mispredict", mispredict, exp_mp);
            chk("mispredict_cnt", mispredict_cnt, exp_cnt);
        end
    endtask

    task automatic set_upd(input logic v, input int idx, input logic [1:0] s, input logic t);
        upd_valid = v;
        upd_idx   = IDX_W'(idx);
        upd_state = s;
        upd_taken = t;
    endtask

    initial begin
        model_reset();
        quiet = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_idx", rsp_idx, 0);
        chk("rst_rsp_state", rsp_state, 0);
        chk("rst_mispredict_cnt", mispredict_cnt, 0);
        rst = 1'b0;

        // Basic lookup, then mispredicting and confirming updates on idx 5.
        req_valid = 1; req_idx = 5; step();
        req_valid = 0; set_upd(1, 5, 2'b01, 1); step();
        set_upd(0, 0, 2'b00, 0); req_valid = 1; req_idx = 5; step();
        req_valid = 0; set_upd(1, 5, 2'b10, 1); step();
        set_upd(0, 0, 2'b00, 0); req_valid = 1; req_idx = 5; step();
        req_valid = 0; step();

        // All eight (state, taken) pairs on idx 0, each read back.
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < 2; t++) begin
                req_valid = 0; set_upd(1, 0, 2'(s), 1'(t)); step();
                set_upd(0, 0, 2'b00, 0); req_valid = 1; req_idx = 0; step();
            end
        end
        req_valid = 0; step();

        // Same-edge lookup and update: same index forwards, other index does not.
        req_valid = 1; req_idx = 9;  set_upd(1, 9, 2'b01, 1); step();
        req_valid = 1; req_idx = 11; set_upd(1, 3, 2'b01, 1); step();
        req_valid = 0; set_upd(0, 0, 2'b00, 0); step();

        // Stall on idx 2 while an update to idx 2 lands, then release.
        req_valid = 1; req_idx = 2; rsp_ready = 1; step();
        rsp_ready = 0; set_upd(1, 2, 2'b01, 1); step();
        set_upd(0, 0, 2'b00, 0); step();
        step();
        rsp_ready = 1; step();
        req_valid = 0; step();

        // Drive the statistic into saturation.
        quiet = 1'b1;
        set_upd(1, 7, 2'b00, 1);
        for (int n = 0; n < 65540; n++) step();
        quiet = 1'b0;
        step();
        step();
        set_upd(0, 0, 2'b00, 0);
        $display("saturation phase done cnt=%0h", mispredict_cnt);

        // Asynchronous reset in the middle of a stall.
        req_valid = 1; req_idx = 12; set_upd(1, 12, 2'b00, 1); step();
        rsp_ready = 0; req_idx = 13; set_upd(0, 0, 2'b00, 0); step();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_rsp_state", rsp_state, 0);
        chk("async_mispredict", mispredict, 0);
        chk("async_cnt", mispredict_cnt, 0);
        chk("async_req_ready", req_ready, 1);
        req_valid = 0; rsp_ready = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Every entry must read back as weak not-taken, back to back.
        for (int i = 0; i < 64; i++) begin
            req_valid = 1; req_idx = IDX_W'(i); step();
        end
        req_valid = 0; step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
